// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one line-read/word-write memory between instruction and data ports
module mem_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic         clock,
  input  logic         resetN,
  input  logic         iReq,
  input  logic [31:0]  iAddr,
  output logic         iReady,
  output logic [511:0] iData,
  input  logic         dReq,
  input  logic         dWrite,
  input  logic [31:0]  dAddr,
  input  logic [31:0]  dWData,
  output logic         dReady,
  output logic [511:0] dData,
  output logic [31:0]  memReadAddress,
  output logic         memReadStart,
  input  logic         memReadEnable,
  input  logic [511:0] memData,
  output logic [31:0]  memWriteAddress,
  output logic [31:0]  memWriteData,
  output logic         memWriteRequest,
  input  logic         memWriteDone,
  output logic         busy,
  output logic         timeoutError
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;
  state_t state_q, state_d;
  logic port_q, port_d;
  logic write_q, write_d;
  logic last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic iready_q, iready_d, dready_q, dready_d;
  logic [511:0] idata_q, idata_d, ddata_q, ddata_d;
  logic [31:0] raddr_q, raddr_d, waddr_q, waddr_d, wdata_q, wdata_d;
  logic rstart_q, rstart_d, wreq_q, wreq_d, busy_q, busy_d, terr_q, terr_d;
  logic pick, done, tout;
  assign cnt_inc = cnt_q + 1'b1;
  // next state: port 1 is the data port; status is ignored while the WAIT counter is still zero
  always_comb begin
    state_d = state_q;
    port_d = port_q;
    write_d = write_q;
    last_d = last_q;
    cnt_d = cnt_q;
    iready_d = 1'b0;
    dready_d = 1'b0;
    rstart_d = 1'b0;
    idata_d = idata_q;
    ddata_d = ddata_q;
    raddr_d = raddr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wreq_d = wreq_q;
    terr_d = terr_q;
    pick = (iReq && dReq) ? ~last_q : dReq;
    done = (cnt_q != '0) && (write_q ? memWriteDone : memReadEnable);
    tout = !done && (cnt_inc == CW'(TIMEOUT));
    case (state_q)
      IDLE: if (iReq || dReq) begin
        state_d = ISSUE;
        port_d = pick;
        write_d = pick && dWrite;
        if (pick && dWrite) begin
          waddr_d = dAddr;
          wdata_d = dWData;
          wreq_d = 1'b1;
        end else begin
          raddr_d = (pick ? dAddr : iAddr) & ~32'h3f;
          rstart_d = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d = '0;
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (done || tout) begin
          state_d = RESPOND;
          wreq_d = 1'b0;
          terr_d = terr_q || tout;
          iready_d = !port_q;
          dready_d = port_q;
          if (!port_q) idata_d = tout ? '0 : memData;
          if (port_q && !write_q) ddata_d = tout ? '0 : memData;
        end
      end
      default: begin
        state_d = IDLE;
        last_d = port_q;
      end
    endcase
    busy_d = state_d != IDLE;
  end
  // state and registered outputs, all cleared asynchronously
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      port_q <= 1'b0;
      write_q <= 1'b0;
      last_q <= 1'b1;
      cnt_q <= '0;
      iready_q <= 1'b0;
      dready_q <= 1'b0;
      idata_q <= '0;
      ddata_q <= '0;
      raddr_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      rstart_q <= 1'b0;
      wreq_q <= 1'b0;
      busy_q <= 1'b0;
      terr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      port_q <= port_d;
      write_q <= write_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      iready_q <= iready_d;
      dready_q <= dready_d;
      idata_q <= idata_d;
      ddata_q <= ddata_d;
      raddr_q <= raddr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      rstart_q <= rstart_d;
      wreq_q <= wreq_d;
      busy_q <= busy_d;
      terr_q <= terr_d;
    end
  end
  assign iReady = iready_q;
  assign iData = idata_q;
  assign dReady = dready_q;
  assign dData = ddata_q;
  assign memReadAddress = raddr_q;
  assign memReadStart = rstart_q;
  assign memWriteAddress = waddr_q;
  assign memWriteData = wdata_q;
  assign memWriteRequest = wreq_q;
  assign busy = busy_q;
  assign timeoutError = terr_q;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 TIMEOUT, default 64: the maximum number of WAIT cycles allowed for a memory completion.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 resetN  input  1  asynchronous active-low reset.
REQ-004 iReq  input  1  instruction-port line-read request, held until iReady.
REQ-005 iAddr  input  32  instruction-port byte address.
REQ-006 iReady  output  1  one-cycle completion pulse for the instruction port.
REQ-007 iData  output  512  line returned to the instruction port.
REQ-008 dReq  input  1  data-port request, held until dReady.
REQ-009 dWrite  input  1  data-port operation select: 1 = word write, 0 = line read.
REQ-010 dAddr  input  32  data-port byte address.
REQ-011 dWData  input  32  data-port write word.
REQ-012 dReady  output  1  one-cycle completion pulse for the data port.
REQ-013 dData  output  512  line returned to the data port.
REQ-014 memReadAddress  output  32  line-aligned read address to memory.
REQ-015 memReadStart  output  1  one-cycle read-start strobe to memory.
REQ-016 memReadEnable  input  1  memory read status: 1 = idle or complete.
REQ-017 memData  input  512  line data from memory.
REQ-018 memWriteAddress  output  32  write byte address to memory.
REQ-019 memWriteData  output  32  write word to memory.
REQ-020 memWriteRequest  output  1  level write request, held until memWriteDone.
REQ-021 memWriteDone  input  1  memory write status: 1 = idle or complete.
REQ-022 busy  output  1  high whenever the FSM is not in IDLE.
REQ-023 timeoutError  output  1  sticky memory-timeout flag.

Function
REQ-024 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT and RESPOND; all outputs SHALL be registered.
REQ-025 In IDLE, requests SHALL be sampled on each rising edge.
- Only one request high: that port is granted.
- Both high: the port not recorded in lastGrant is granted (round-robin).
- On grant: address, dWrite and dWData are latched, and the FSM moves to ISSUE.
REQ-026 In ISSUE (exactly one cycle), for a read:
- memReadAddress SHALL equal {addr[31:6], 6'b0}.
- memReadStart SHALL be high for this cycle only.
REQ-027 In ISSUE, for a write: memWriteAddress = dAddr, memWriteData = dWData, and memWriteRequest SHALL rise and stay high until completion or timeout.
REQ-028 WAIT behaviour:
- The status input (memReadEnable for a read, memWriteDone for a write) SHALL be ignored on the first WAIT edge.
- From the second WAIT edge onward, status high completes the access: for a read, memData is captured; for a write, memWriteRequest falls on that same edge.
- The FSM then moves to RESPOND.
REQ-029 A WAIT cycle counter SHALL be cleared on entry to WAIT and increment every WAIT cycle.
- If the counter reaches TIMEOUT with status still low: timeoutError is set, the captured line is forced to zero, and the FSM moves to RESPOND.
- If status is high on the same edge the counter reaches TIMEOUT, completion SHALL win and no error is set.
REQ-030 In RESPOND (exactly one cycle):
- The granted port's ready output SHALL pulse high.
- For reads, its data output is updated and then held until that port's next read response.
- A write response SHALL leave dData unchanged.
- lastGrant is updated to the granted port, and the FSM returns to IDLE.
REQ-031 Minimum read latency: a request sampled on edge N with status first seen high SHALL give ready high in the cycle after edge N+3.
REQ-032 Requests arriving outside IDLE SHALL be ignored until IDLE; requesters SHALL drop req in the cycle after ready, so no duplicate grant occurs.
REQ-033 The latched address and write data SHALL NOT change between grant and RESPOND, regardless of input changes.

Reset
REQ-034 Asserting resetN low SHALL immediately force state IDLE, all outputs to 0 (including iData, dData, addresses and timeoutError), and lastGrant = data port, from any state including mid-WAIT.
REQ-035 After resetN is released, the first tie SHALL be granted to the instruction port.

Verification
REQ-036 Single read: iReq=1, iAddr=0x0000_0048, memory completes at the first sampled WAIT edge -> memReadAddress=0x0000_0040, one memReadStart pulse, iReady pulses after edge N+3, iData = memData.
REQ-037 Tie after reset: iReq=dReq=1 (dWrite=0) -> instruction served first, then data; iReady and dReady each pulse exactly once.
REQ-038 Write: dReq=1, dWrite=1, dAddr=0x84, dWData=0xDEADBEEF, memWriteDone low for 3 cycles then high -> memWriteRequest held high throughout, falls with completion, dReady pulses once, dData unchanged.
REQ-039 Timeout: TIMEOUT=4, memReadEnable held low -> after 4 WAIT cycles, timeoutError=1 (sticky), the granted port's ready pulses with data 0, and the next request is still served.
REQ-040 Reset mid-operation: resetN low during WAIT of a write -> memWriteRequest, busy and all other outputs go to 0 immediately; after release, a new dReq completes normally.
